// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_pkg
// Purpose  : Shared types and constants for the CP0 interrupt source block:
//            FSM state encoding, register map and INFO field offsets.
// Revision : 1.0 - initial release
// ============================================================================
package intr_ctrl_pkg;

    // Request/acknowledge/eret handshake with CP0
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Register port addresses
    localparam logic [1:0] c_addr_mask      = 2'd0;
    localparam logic [1:0] c_addr_pending   = 2'd1;
    localparam logic [1:0] c_addr_timer_cmp = 2'd2;
    localparam logic [1:0] c_addr_info      = 2'd3;

    // Source index owned by the internal compare timer
    localparam int c_timer_src = 0;

    // INFO register layout
    localparam int c_info_state_lsb = 8;
    localparam int c_info_id_lsb    = 0;

endpackage : intr_ctrl_pkg
`default_nettype wire

// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_if
// Purpose  : Register port plus CP0 handshake between the CPU core and the
//            interrupt source block.
// Revision : 1.0 - initial release
// ============================================================================
interface intr_ctrl_if #(
    parameter int N_SRC = 8
);
    localparam int ID_W = $clog2(N_SRC);

    logic            reg_we;
    logic [1:0]      reg_addr;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;
    logic [31:0]     cp0_status;
    logic            int_ack;
    logic            eret;
    logic            intr;
    logic [ID_W-1:0] irq_id;

    // CPU / CP0 side
    modport master (
        output reg_we, reg_addr, reg_wdata, cp0_status, int_ack, eret,
        input  reg_rdata, intr, irq_id
    );

    // Interrupt controller side
    modport slave (
        input  reg_we, reg_addr, reg_wdata, cp0_status, int_ack, eret,
        output reg_rdata, intr, irq_id
    );

endinterface : intr_ctrl_if
`default_nettype wire

// File: rtl/intr_timer.sv
`default_nettype none
// ============================================================================
// Module   : intr_timer
// Purpose  : Free-running compare timer. Counts while the compare value is
//            non-zero and emits a one-cycle wrap pulse on count==cmp-1.
// Revision : 1.0 - initial release
// ============================================================================
module intr_timer #(
    parameter int TIMER_W = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               cmp_we,
    input  wire logic [TIMER_W-1:0] cmp_wdata,
    output logic      [TIMER_W-1:0] cmp,
    output logic                    wrap
);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] r_cmp;

    // A compare write restarts the period, so no wrap is reported that cycle
    assign wrap = (r_cmp != '0) && (r_count == (r_cmp - 1'b1)) && !cmp_we;
    assign cmp  = r_cmp;

    // Compare register and counter; cmp==0 parks the counter at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp   <= '0;
            r_count <= '0;
        end else if (cmp_we) begin
            r_cmp   <= cmp_wdata;
            r_count <= '0;
        end else if (r_cmp == '0 || wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : intr_timer
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Purpose  : Latches, masks and prioritises peripheral and timer interrupts
//            and drives a single registered request into CP0, tracking
//            ack/eret so each event is delivered exactly once.
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl #(
    parameter int N_SRC   = 8,
    parameter int TIMER_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [N_SRC-2:0] src_irq,
    intr_ctrl_if.slave            bus
);
    import intr_ctrl_pkg::*;

    localparam int ID_W = $clog2(N_SRC);

    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-2:0]   r_src_prev;
    state_t             r_state;
    logic               r_intr;
    logic [ID_W-1:0]    r_irq_id;

    state_t             w_state_nxt;
    logic               w_intr_nxt;
    logic [ID_W-1:0]    w_irq_id_nxt;
    logic               w_ack_clr;
    logic [ID_W-1:0]    w_lowest;
    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_set;
    logic [N_SRC-1:0]   w_clr;
    logic [N_SRC-1:0]   w_pending_nxt;
    logic               w_enable;
    logic               w_mask_we;
    logic               w_pend_we;
    logic               w_cmp_we;
    logic               w_wrap;
    logic [TIMER_W-1:0] w_cmp;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_mask_we = bus.reg_we && (bus.reg_addr == c_addr_mask);
    assign w_pend_we = bus.reg_we && (bus.reg_addr == c_addr_pending);
    assign w_cmp_we  = bus.reg_we && (bus.reg_addr == c_addr_timer_cmp);

    assign w_enable   = bus.cp0_status[0] & bus.cp0_status[4];
    assign w_eligible = r_pending & r_mask;

    // Only the status enable bits and the low data bits are consumed
    assign w_unused = &{1'b0, bus.cp0_status, bus.reg_wdata};

    intr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp_we    (w_cmp_we),
        .cmp_wdata (bus.reg_wdata[TIMER_W-1:0]),
        .cmp       (w_cmp),
        .wrap      (w_wrap)
    );

    // Rising edges of peripheral lines sit above the timer bit; sets beat clears
    always_comb begin
        w_set                = {src_irq & ~r_src_prev, 1'b0};
        w_set[c_timer_src]   = w_wrap;
        w_clr                = '0;
        if (w_pend_we) begin
            w_clr = bus.reg_wdata[N_SRC-1:0];
        end
        if (w_ack_clr) begin
            w_clr = w_clr | (N_SRC'(1) << r_irq_id);
        end
        w_pending_nxt = (r_pending & ~w_clr) | w_set;
    end

    // Lowest eligible index wins
    always_comb begin
        w_lowest = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_lowest = ID_W'(i);
            end
        end
    end

    // Mask, pending latch and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_pending  <= '0;
            r_src_prev <= '0;
        end else begin
            if (w_mask_we) begin
                r_mask <= bus.reg_wdata[N_SRC-1:0];
            end
            r_pending  <= w_pending_nxt;
            r_src_prev <= src_irq;
        end
    end

    // Handshake FSM next state; irq_id is frozen once a request is raised
    always_comb begin
        w_state_nxt  = r_state;
        w_intr_nxt   = r_intr;
        w_irq_id_nxt = r_irq_id;
        w_ack_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|w_eligible) && w_enable) begin
                    w_state_nxt  = REQ;
                    w_intr_nxt   = 1'b1;
                    w_irq_id_nxt = w_lowest;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    w_state_nxt = SERVICE;
                    w_intr_nxt  = 1'b0;
                    w_ack_clr   = 1'b1;
                end else if (!w_eligible[r_irq_id] || !w_enable) begin
                    w_state_nxt = IDLE;
                    w_intr_nxt  = 1'b0;
                end
            end
            SERVICE: begin
                if (bus.eret) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_intr_nxt  = 1'b0;
            end
        endcase
    end

    // Handshake FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_intr   <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_intr   <= w_intr_nxt;
            r_irq_id <= w_irq_id_nxt;
        end
    end

    // Register read mux; forced to zero while reset is asserted
    always_comb begin
        w_rdata = '0;
        if (rst_n) begin
            case (bus.reg_addr)
                c_addr_mask:      w_rdata[N_SRC-1:0]   = r_mask;
                c_addr_pending:   w_rdata[N_SRC-1:0]   = r_pending;
                c_addr_timer_cmp: w_rdata[TIMER_W-1:0] = w_cmp;
                c_addr_info: begin
                    w_rdata[c_info_state_lsb +: 2] = r_state;
                    w_rdata[c_info_id_lsb +: ID_W] = r_irq_id;
                end
            endcase
        end
    end

    assign bus.reg_rdata = w_rdata;
    assign bus.intr      = r_intr;
    assign bus.irq_id    = r_irq_id;

endmodule : intr_ctrl
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_ctrl
// Purpose  : Self-checking bench for intr_ctrl: vector table for single
//            request scenarios plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

    localparam int N_SRC = 8;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_CMP  = 2'd2;
    localparam logic [1:0] A_INFO = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [6:0] src_irq;

    int checks = 0;
    int errors = 0;

    intr_ctrl_if #(.N_SRC(N_SRC)) bus();

    intr_ctrl #(
        .N_SRC   (N_SRC),
        .TIMER_W (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_irq (src_irq),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  src;
        logic [7:0]  mask;
        logic [31:0] status;
        logic [7:0]  exp_pend;
        logic        exp_intr;
        logic [2:0]  exp_id;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        src_irq        = '0;
        bus.reg_we     = 1'b0;
        bus.reg_addr   = '0;
        bus.reg_wdata  = '0;
        bus.cp0_status = '0;
        bus.int_ack    = 1'b0;
        bus.eret       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] exp_info;

        vecs[0] = '{7'h04, 8'hFF, 32'h1F, 8'h08, 1'b1, 3'd3};
        vecs[1] = '{7'h11, 8'hFF, 32'h1F, 8'h22, 1'b1, 3'd1};
        vecs[2] = '{7'h40, 8'h7F, 32'h1F, 8'h80, 1'b0, 3'd0};
        vecs[3] = '{7'h0A, 8'hFF, 32'h01, 8'h14, 1'b0, 3'd0};
        vecs[4] = '{7'h7F, 8'hF0, 32'h11, 8'hFE, 1'b1, 3'd4};
        vecs[5] = '{7'h01, 8'hFF, 32'h10, 8'h02, 1'b0, 3'd0};

        // Reset state
        do_reset();
        check("reset_intr", 32'(bus.intr), 32'h0);
        check("reset_id", 32'(bus.irq_id), 32'h0);
        rd(A_MASK, d); check("reset_mask", d, 32'h0);
        rd(A_PEND, d); check("reset_pend", d, 32'h0);
        rd(A_CMP, d);  check("reset_cmp", d, 32'h0);
        rd(A_INFO, d); check("reset_info", d, 32'h0);

        // Vector table: one edge burst, then pending and request outcome
        for (int v = 0; v < 6; v++) begin
            do_reset();
            wr(A_MASK, 32'(vecs[v].mask));
            bus.cp0_status = vecs[v].status;
            src_irq = vecs[v].src;
            tick();
            rd(A_PEND, d); check($sformatf("vec%0d_pend", v), d, 32'(vecs[v].exp_pend));
            src_irq = '0;
            tick();
            check($sformatf("vec%0d_intr", v), 32'(bus.intr), 32'(vecs[v].exp_intr));
            check($sformatf("vec%0d_id", v), 32'(bus.irq_id), 32'(vecs[v].exp_id));
            exp_info = (vecs[v].exp_intr ? 32'h100 : 32'h0) | 32'(vecs[v].exp_id);
            rd(A_INFO, d); check($sformatf("vec%0d_info", v), d, exp_info);
        end

        // Held level: one event, ack clears, eret returns to IDLE
        do_reset();
        wr(A_MASK, 32'hFF);
        bus.cp0_status = 32'h1F;
        src_irq = 7'h04;
        tick();
        rd(A_PEND, d); check("s1_pend", d, 32'h08);
        check("s1_intr_early", 32'(bus.intr), 32'h0);
        tick();
        check("s1_intr", 32'(bus.intr), 32'h1);
        check("s1_id", 32'(bus.irq_id), 32'h3);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check("s1_intr_ack", 32'(bus.intr), 32'h0);
        rd(A_PEND, d); check("s1_pend_ack", d, 32'h0);
        rd(A_INFO, d); check("s1_info_svc", d, 32'h203);
        for (int i = 0; i < 7; i++) tick();
        rd(A_PEND, d); check("s1_pend_held", d, 32'h0);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        src_irq = '0;
        rd(A_INFO, d); check("s1_info_idle", d, 32'h003);

        // Simultaneous edges: lowest first, second after ack+eret and an IDLE gap
        do_reset();
        wr(A_MASK, 32'hFF);
        bus.cp0_status = 32'h1F;
        src_irq = 7'h11;
        tick();
        src_irq = '0;
        tick();
        check("s2_id_first", 32'(bus.irq_id), 32'h1);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        rd(A_PEND, d); check("s2_pend_left", d, 32'h20);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        check("s2_idle_gap", 32'(bus.intr), 32'h0);
        tick();
        check("s2_intr_second", 32'(bus.intr), 32'h1);
        check("s2_id_second", 32'(bus.irq_id), 32'h5);

        // Timer: period 5 with continuous W1C of bit 0, then timer off
        do_reset();
        wr(A_CMP, 32'd5);
        rd(A_CMP, d); check("s3_cmp_rd", d, 32'd5);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = A_PEND;
        bus.reg_wdata = 32'h1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("s3_tick%0d", k), bus.reg_rdata & 32'h1, (k % 5 == 0) ? 32'h1 : 32'h0);
        end
        bus.reg_we = 1'b0;
        wr(A_CMP, 32'd0);
        for (int k = 1; k <= 12; k++) tick();
        rd(A_PEND, d); check("s3_off", d & 32'h1, 32'h0);

        // W1C of the requested bit, and enable drop, both withdraw the request
        do_reset();
        wr(A_MASK, 32'hFF);
        bus.cp0_status = 32'h1F;
        src_irq = 7'h04;
        tick();
        src_irq = '0;
        tick();
        check("s4_req", 32'(bus.intr), 32'h1);
        wr(A_PEND, 32'h08);
        tick();
        check("s4_w1c_intr", 32'(bus.intr), 32'h0);
        rd(A_INFO, d); check("s4_w1c_info", d, 32'h003);
        src_irq = 7'h02;
        tick();
        src_irq = '0;
        tick();
        check("s4_req2", 32'(bus.intr), 32'h1);
        bus.cp0_status = 32'h1E;
        tick();
        check("s4_ie_intr", 32'(bus.intr), 32'h0);
        rd(A_INFO, d); check("s4_ie_info", d, 32'h002);
        rd(A_PEND, d); check("s4_ie_pend", d, 32'h04);
        bus.cp0_status = 32'h1F;
        tick();
        check("s4_rereq", 32'(bus.intr), 32'h1);
        check("s4_rereq_id", 32'(bus.irq_id), 32'h2);

        // Set beats W1C on the same bit; ack ignored in IDLE
        do_reset();
        wr(A_MASK, 32'hFF);
        src_irq = 7'h04;
        tick();
        src_irq = '0;
        tick();
        src_irq       = 7'h04;
        bus.reg_we    = 1'b1;
        bus.reg_addr  = A_PEND;
        bus.reg_wdata = 32'h08;
        tick();
        bus.reg_we = 1'b0;
        rd(A_PEND, d); check("s5_set_wins", d, 32'h08);
        src_irq = '0;
        wr(A_PEND, 32'h08);
        rd(A_PEND, d); check("s5_w1c", d, 32'h0);
        src_irq = 7'h04;
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        rd(A_PEND, d); check("s5_ack_idle_pend", d, 32'h08);
        rd(A_INFO, d); check("s5_ack_idle_info", d, 32'h0);
        src_irq = '0;

        // Asynchronous reset while in SERVICE
        do_reset();
        wr(A_MASK, 32'hFF);
        bus.cp0_status = 32'h1F;
        src_irq = 7'h19;
        tick();
        src_irq = '0;
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        rd(A_PEND, d); check("s6_pend_svc", d, 32'h30);
        rd(A_INFO, d); check("s6_info_svc", d, 32'h201);
        rst_n = 1'b0;
        #1;
        check("s6_rst_intr", 32'(bus.intr), 32'h0);
        rd(A_MASK, d); check("s6_rst_mask", d, 32'h0);
        rd(A_PEND, d); check("s6_rst_pend", d, 32'h0);
        rd(A_INFO, d); check("s6_rst_info", d, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(A_PEND, d); check("s6_after_pend", d, 32'h0);
        check("s6_after_intr", 32'(bus.intr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_intr_ctrl
`default_nettype wire
